// File: rtl/ram_scan_reader.sv
// ram_scan_reader: reads one word or scans a synchronous RAM for a hex display.
// Optional build macro RAM_SCAN_READER_CHECKSUM_EN adds an 8-bit running sum output.
module ram_scan_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int DWELL  = 50000000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              mode,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] q_addr,
    output logic              q_valid,
`ifdef RAM_SCAN_READER_CHECKSUM_EN
    output logic [7:0]        sum,
`endif
    output logic              busy
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              scan_q, scan_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] qaddr_q, qaddr_d;
    logic              valid_q, valid_d;
`ifdef RAM_SCAN_READER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // Next-state, capture and read-strobe decode; stop aborts before capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        scan_d  = scan_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        qaddr_d = qaddr_q;
        valid_d = 1'b0;
        rd_en   = 1'b0;
`ifdef RAM_SCAN_READER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_REQ;
                    addr_d  = start_addr;
                    scan_d  = mode;
`ifdef RAM_SCAN_READER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            S_REQ: begin
                rd_en = 1'b1;
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    data_d  = rd_data;
                    qaddr_d = addr_q;
                    valid_d = 1'b1;
`ifdef RAM_SCAN_READER_CHECKSUM_EN
                    sum_d   = sum_q + 8'(rd_data);
`endif
                    if (scan_q) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            scan_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            qaddr_q <= '0;
            valid_q <= 1'b0;
`ifdef RAM_SCAN_READER_CHECKSUM_EN
            sum_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            scan_q  <= scan_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            qaddr_q <= qaddr_d;
            valid_q <= valid_d;
`ifdef RAM_SCAN_READER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign rd_addr = addr_q;
    assign q       = data_q;
    assign q_addr  = qaddr_q;
    assign q_valid = valid_q;
    assign busy    = (state_q != S_IDLE);
`ifdef RAM_SCAN_READER_CHECKSUM_EN
    assign sum     = sum_q;
`endif

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader with a registered-read RAM model.
// Checksum checks are built only when RAM_SCAN_READER_CHECKSUM_EN is defined.
module tb_ram_scan_reader;

    localparam int AW = 5;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic          start;
    logic          mode;
    logic          stop;
    logic [AW-1:0] start_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] q;
    logic [AW-1:0] q_addr;
    logic          q_valid;
    logic          busy;
`ifdef RAM_SCAN_READER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    logic [DW-1:0] mem [32];

    int checks = 0;
    int errors = 0;

    ram_scan_reader #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DWELL (2)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .mode      (mode),
        .stop      (stop),
        .start_addr(start_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .q         (q),
        .q_addr    (q_addr),
        .q_valid   (q_valid),
`ifdef RAM_SCAN_READER_CHECKSUM_EN
        .sum       (sum),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Synchronous RAM: data one cycle after the strobe.
    always @(posedge clock) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_q"}, 32'(q), 32'd0);
        chk({tag, "_q_addr"}, 32'(q_addr), 32'd0);
        chk({tag, "_q_valid"}, 32'(q_valid), 32'd0);
    endtask

    initial begin
        int a;
        int gap;
        resetn     = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        stop       = 1'b0;
        start_addr = '0;
        for (int i = 0; i < 32; i++) mem[i] = 4'(i + 1);
        mem[5] = 4'hA;

        tick();
        tick();
        chk_idle_zero("reset");
`ifdef RAM_SCAN_READER_CHECKSUM_EN
        chk("reset_sum", 32'(sum), 32'd0);
`endif
        resetn = 1'b1;
        tick();

        // Single read of address 5
        start = 1'b1; mode = 1'b0; start_addr = 5'd5;
        tick();
        start = 1'b0;
        chk("single_rd_en", 32'(rd_en), 32'd1);
        chk("single_rd_addr", 32'(rd_addr), 32'd5);
        chk("single_busy", 32'(busy), 32'd1);
        tick();
        chk("single_capt_rd_en", 32'(rd_en), 32'd0);
        chk("single_capt_valid", 32'(q_valid), 32'd0);
        tick();
        chk("single_q", 32'(q), 32'hA);
        chk("single_q_addr", 32'(q_addr), 32'd5);
        chk("single_q_valid", 32'(q_valid), 32'd1);
        chk("single_busy_low", 32'(busy), 32'd0);
        tick();
        chk("single_pulse_end", 32'(q_valid), 32'd0);
        chk("single_q_hold", 32'(q), 32'hA);

        // Stop wins over start in IDLE
        start = 1'b1; stop = 1'b1; start_addr = 5'd9;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("stopwin_busy", 32'(busy), 32'd0);
        chk("stopwin_rd_addr", 32'(rd_addr), 32'd5);

        // Scan with wrap from 30: pulses 4 cycles apart
        start = 1'b1; mode = 1'b1; start_addr = 5'd30;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a   = (30 + k) % 32;
            gap = (k == 0) ? 2 : 4;
            for (int c = 1; c <= gap; c++) begin
                tick();
                if (c < gap) begin
                    chk($sformatf("wrap%0d_gap%0d", k, c), 32'(q_valid), 32'd0);
                end else begin
                    chk($sformatf("wrap%0d_valid", k), 32'(q_valid), 32'd1);
                    chk($sformatf("wrap%0d_q_addr", k), 32'(q_addr), 32'(a));
                    chk($sformatf("wrap%0d_q", k), 32'(q), 32'(mem[a]));
                end
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("wrap_stop_busy", 32'(busy), 32'd0);
        chk("wrap_stop_valid", 32'(q_valid), 32'd0);

        // Stop during CAPT of address 7
        start = 1'b1; mode = 1'b1; start_addr = 5'd6;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("capt_first_valid", 32'(q_valid), 32'd1);
        chk("capt_first_addr", 32'(q_addr), 32'd6);
        tick();
        tick();
        chk("capt_req_rd_en", 32'(rd_en), 32'd1);
        chk("capt_req_rd_addr", 32'(rd_addr), 32'd7);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("capt_stop_busy", 32'(busy), 32'd0);
        chk("capt_stop_valid", 32'(q_valid), 32'd0);
        chk("capt_stop_q_addr", 32'(q_addr), 32'd6);
        chk("capt_stop_q", 32'(q), 32'(mem[6]));
        tick();
        chk("capt_stop_valid2", 32'(q_valid), 32'd0);

        // Start while busy is ignored
        start = 1'b1; mode = 1'b1; start_addr = 5'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("busy_first_addr", 32'(q_addr), 32'd10);
        chk("busy_first_valid", 32'(q_valid), 32'd1);
        start = 1'b1; start_addr = 5'd20;
        tick();
        start = 1'b0;
        tick();
        chk("busy_req_rd_en", 32'(rd_en), 32'd1);
        chk("busy_req_rd_addr", 32'(rd_addr), 32'd11);
        tick();
        tick();
        chk("busy_second_valid", 32'(q_valid), 32'd1);
        chk("busy_second_addr", 32'(q_addr), 32'd11);

        // Reset mid-HOLD, then single read from 0
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk_idle_zero("midreset");
        start = 1'b1; mode = 1'b0; start_addr = 5'd0;
        tick();
        start = 1'b0;
        chk("after_rst_rd_en", 32'(rd_en), 32'd1);
        chk("after_rst_rd_addr", 32'(rd_addr), 32'd0);
        tick();
        tick();
        chk("after_rst_q", 32'(q), 32'(mem[0]));
        chk("after_rst_valid", 32'(q_valid), 32'd1);
        chk("after_rst_busy", 32'(busy), 32'd0);

`ifdef RAM_SCAN_READER_CHECKSUM_EN
        // Running sum of words 1,2,3,4 scanned from address 0
        tick();
        start = 1'b1; mode = 1'b1; start_addr = 5'd0;
        tick();
        start = 1'b0;
        chk("sum_cleared_scan", 32'(sum), 32'd0);
        tick();
        tick();
        for (int k = 1; k < 4; k++) begin
            tick(); tick(); tick(); tick();
        end
        chk("sum_fourth_valid", 32'(q_valid), 32'd1);
        chk("sum_fourth_addr", 32'(q_addr), 32'd3);
        chk("sum_value", 32'(sum), 32'd10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b1; mode = 1'b0; start_addr = 5'd3;
        tick();
        start = 1'b0;
        chk("sum_restart_clear", 32'(sum), 32'd0);
        tick();
        tick();
        chk("sum_single", 32'(sum), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
